// File: rtl/pipe_pkg.sv
// Shared types and constants for the handshaked pipeline-stage registers.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/stage_entry.sv
// One {valid, data, ctrl} holding register; ctrl reads as zero whenever the entry is invalid.
module stage_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // NOTE: non-blocking assignments keep every register in this block updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data is reset here so a freshly reset stage presents zero; clear leaves it as a don't-care.
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_valid ? r_ctrl : '0;

endmodule

// File: rtl/elastic_stage_reg.sv
// Elastic pipeline-stage register: main + skid entry, flush/freeze, no out_ready -> in_ready path.
// Define ELASTIC_STAGE_PERF_EN to add the saturating stall_cnt / bubble_cnt outputs.
module elastic_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef ELASTIC_STAGE_PERF_EN
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] bubble_cnt
`else
    output logic [CTRL_W-1:0] out_ctrl
`endif
);

    logic              w_main_valid, w_skid_valid;
    logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_d;
    logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_c;
    logic              w_main_load, w_main_clear, w_main_from_skid;
    logic              w_skid_load, w_skid_clear;
    logic              w_in_fire, w_out_fire;
    occ_e              w_occ;

    // Handshakes see only registered valids plus the flush/freeze/rst inputs.
    assign in_ready   = ~w_skid_valid & ~freeze & ~flush & ~rst;
    assign out_valid  = w_main_valid & ~freeze & ~flush & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        w_occ = EMPTY;
        if (w_skid_valid)      w_occ = TWO;
        else if (w_main_valid) w_occ = ONE;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        w_main_load      = 1'b0;
        w_main_clear     = flush;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = flush;
        case (w_occ)
            EMPTY: w_main_load = w_in_fire;
            ONE: begin
                if (w_in_fire && w_out_fire) w_main_load  = 1'b1;
                else if (w_in_fire)          w_skid_load  = 1'b1;
                else if (w_out_fire)         w_main_clear = 1'b1;
            end
            TWO: begin
                if (w_out_fire) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_skid_clear     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_main_d = w_main_from_skid ? w_skid_data : in_data;
    assign w_main_c = w_main_from_skid ? w_skid_ctrl : in_ctrl;

    stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_data  (w_main_d),
        .i_ctrl  (w_main_c),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    assign out_data = w_main_data;
    assign out_ctrl = out_valid ? w_main_ctrl : '0;

`ifdef ELASTIC_STAGE_PERF_EN
    logic [PERF_CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

    // Counters survive flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready)  r_stall_cnt  <= sat_inc(r_stall_cnt);
            if (!w_main_valid && !freeze) r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
`endif

endmodule

// File: doc/elastic_stage_reg.md
# elastic_stage_reg

Parametrised, handshaked pipeline-stage register that supersedes the fixed-field inter-stage registers of the five-stage core. It carries one opaque data bus and one control bus per stage, with a two-entry skid buffer so that back-pressure from the downstream stage never creates a combinational ready path upstream. It keeps the pipeline's existing flush and freeze semantics. Any stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB) instantiates it with its own widths.

## Interface
- DATA_W, 32: width of payload fields (PC, operands, immediates, register addresses, concatenated by the instantiating stage).
- CTRL_W, 8: width of control fields (wb_enable, mem_read, mem_write, is_branch, status_write_enable, …); zeroed whenever the entry is not valid.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill every held entry.
- freeze  in  1  hold all state, block both handshakes.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  block accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- out_valid  out  1  entry available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control; 0 when out_valid = 0.

## Operation
- Storage: main entry (head) and skid entry, each {valid, data, ctrl}.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~skid.valid & ~freeze & ~flush.
- out_valid = main.valid & ~freeze & ~flush; out_data = main.data; out_ctrl = out_valid ? main.ctrl : 0.
- Occupancy states: EMPTY, ONE (main only), TWO (main + skid).
  - EMPTY: in_fire -> ONE (load main).
  - ONE: in_fire & out_fire -> ONE (main <= in); in_fire only -> TWO (skid <= in); out_fire only -> EMPTY.
  - TWO: in_ready = 0; out_fire -> ONE (main <= skid); otherwise stay.
- Priority per cycle: rst > flush > freeze > handshakes.
- flush: both valids cleared next edge, control fields cleared; data fields keep previous value (don't-care). flush with freeze asserted: flush wins.
- freeze: no state change, no fire on either side; out_data stays stable.
- Order preserved: skid entry always younger than main.

## Timing
- Reset: out_valid 0, in_ready 1 the cycle after rst deasserts (0 while rst high), out_data 0, out_ctrl 0, state EMPTY, perf counters 0.
- Latency: entry accepted at edge N is on out_* after edge N (one cycle), when EMPTY or ONE with out_fire.
- Throughput: one entry per cycle sustained with out_ready held high.
- in_ready depends only on registered skid.valid plus freeze/flush inputs; no path from out_ready to in_ready.
- out_ready dropped in ONE: at most one more entry absorbed (TWO), then in_ready = 0 from the next cycle.
- rst mid-operation: both entries discarded in one edge regardless of flush/freeze.

## Configuration
- ELASTIC_STAGE_PERF_EN defined: adds outputs stall_cnt and bubble_cnt (each 32 bits). stall_cnt increments on cycles with out_valid & ~out_ready; bubble_cnt on cycles with ~main.valid & ~freeze. Both saturate at all-ones, clear only on rst (not flush).
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package pipe_pkg: occupancy enum (EMPTY, ONE, TWO), PERF_CNT_W = 32, default DATA_W/CTRL_W constants.
- Sub-module stage_entry: one {valid, data, ctrl} register with load, clear (flush/rst), ctrl-zero-on-invalid; instantiated twice (main, skid).

## Test plan
- Reset: rst high 2 cycles with in_valid = 1 -> out_valid 0, out_ctrl 0, out_data 0; in_ready 1 after release.
- Streaming: 8 entries data 0x10..0x17, out_ready = 1 -> identical order, each one cycle after acceptance, no bubbles.
- Back-pressure: out_ready = 0 after first entry 0xA -> 0xB absorbed into skid, in_ready 0; out_ready = 1 -> 0xA then 0xB on consecutive cycles, no loss, no duplicate.
- Flush in TWO with ctrl 0xFF -> next cycle out_valid 0, out_ctrl 0x00, state EMPTY, in_ready 1.
- Freeze 3 cycles in ONE with out_ready = 1 -> out_valid 0, in_ready 0, entry unchanged; released -> same entry delivered once. Freeze+flush together -> entry killed.
- With ELASTIC_STAGE_PERF_EN: 5 back-pressured cycles, 3 empty cycles -> stall_cnt = 5, bubble_cnt = 3; flush leaves both unchanged.
